// File: rtl/riscv_mdu_if.sv
// rtl/riscv_mdu_if.sv - request/result bundle between a requester and the RV32M multiply/divide unit
interface riscv_mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, A, B,
    input  busy, done, result
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result
  );
endinterface

// File: rtl/riscv_mdu.sv
// rtl/riscv_mdu.sv - iterative RV32M multiply/divide unit, 32 radix-2 steps plus one sign-fix edge
module riscv_mdu (
  input  logic        clk,
  input  logic        rst_n,
  riscv_mdu_if.slave  bus
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [5:0] LAST_ITER = 6'd32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  op_r;
  logic        neg_r;
  logic [31:0] b_mag;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;

  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        neg_new;

  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic        div_fits;

  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] dv;
  logic [31:0] dv_fix;
  logic [31:0] fin;

  always_comb begin
    a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg    = a_signed & bus.A[31];
    b_neg    = b_signed & bus.B[31];
    a_abs    = a_neg ? (~bus.A + 32'd1) : bus.A;
    b_abs    = b_neg ? (~bus.B + 32'd1) : bus.B;
    // A zero divisor leaves an all-ones quotient magnitude that must not be negated.
    if (bus.op == OP_REM)
      neg_new = a_neg;
    else if ((bus.op == OP_DIV) && (bus.B == 32'd0))
      neg_new = 1'b0;
    else
      neg_new = a_neg ^ b_neg;
  end

  always_comb begin
    mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag} : 33'd0);
    rem_sh   = {p_hi, p_lo[31]};
    div_diff = {1'b0, rem_sh} - {2'b00, b_mag};
    div_fits = ~div_diff[33];
  end

  always_comb begin
    prod     = {p_hi, p_lo};
    prod_fix = neg_r ? (~prod + 64'd1) : prod;
    dv       = op_r[1] ? p_hi : p_lo;
    dv_fix   = neg_r ? (~dv + 32'd1) : dv;
    if (op_r[2])
      fin = dv_fix;
    else if (op_r == OP_MUL)
      fin = prod_fix[31:0];
    else
      fin = prod_fix[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      op_r     <= 3'd0;
      neg_r    <= 1'b0;
      b_mag    <= 32'd0;
      p_hi     <= 32'd0;
      p_lo     <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r   <= bus.op;
            neg_r  <= neg_new;
            b_mag  <= b_abs;
            p_hi   <= 32'd0;
            p_lo   <= a_abs;
            cnt    <= 6'd0;
            busy_r <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (cnt != LAST_ITER) begin
            // p_hi:p_lo is the product shift register, or remainder:quotient when dividing.
            if (op_r[2]) begin
              p_hi <= div_fits ? div_diff[31:0] : rem_sh[31:0];
              p_lo <= {p_lo[30:0], div_fits};
            end else begin
              p_hi <= mul_sum[32:1];
              p_lo <= {mul_sum[0], p_lo[31:1]};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_r <= fin;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule
